// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {IDLE, BURST, DONE} arb_state_e;

  localparam int unsigned BURST_LEN_W = 4;
  typedef logic [BURST_LEN_W-1:0] burst_len_t;

  localparam int unsigned STARVE_W = 4;
  typedef logic [STARVE_W-1:0] starve_cnt_t;
  localparam starve_cnt_t STARVE_LIM = starve_cnt_t'(8);

  localparam logic [2:0] FUNCT3_WORD = 3'b010;

endpackage

// File: rtl/starve_ctr.sv
// Counts IDLE cycles in which a DMA request is blocked by the core.
// Raises starve once STARVE_LIM such cycles have gone by without a grant.
module starve_ctr
  import dmem_arb_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic inc,
  input  logic clr,
  output logic starve
);

  starve_cnt_t cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != STARVE_LIM)) begin
      cnt_d = cnt_q + starve_cnt_t'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starve = (cnt_q == STARVE_LIM);

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: the MEM-stage core port has priority; a loader/debug requester gets
// word bursts when the core is idle. Define DMEM_ARB_STARVE_EN to bound the DMA wait time.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned LEN_W      = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  core_rd,
  input  logic                  core_wr,
  input  logic [DM_ADDRESS-1:0] core_addr,
  input  logic [DATA_W-1:0]     core_wdata,
  input  logic [2:0]            core_funct3,
  output logic [DATA_W-1:0]     core_rdata,
  output logic                  core_stall,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [DM_ADDRESS-1:0] dma_addr,
  input  logic [LEN_W-1:0]      dma_len,
  input  logic [DATA_W-1:0]     dma_wdata,
  output logic                  dma_gnt,
  output logic                  dma_wready,
  output logic                  dma_rvalid,
  output logic                  dma_done,
  output logic [DATA_W-1:0]     dma_rdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_W-1:0]     mem_rdata
);

  arb_state_e            state_q, state_d;
  logic [DM_ADDRESS-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]      beats_q, beats_d;
  logic                  we_q, we_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  core_busy, idle, starve, grant;

  assign core_busy = core_rd | core_wr;
  assign idle      = (state_q == IDLE);

`ifdef DMEM_ARB_STARVE_EN
  starve_ctr u_starve_ctr (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (idle & dma_req & core_busy),
    .clr     (grant | ~dma_req),
    .starve  (starve)
  );
`else
  assign starve = 1'b0;
`endif

  assign grant = idle & dma_req & (~core_busy | starve);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant) state_d = BURST;
      BURST:   if (beats_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Burst parameters are captured only at grant so requester changes mid-burst are ignored.
  always_comb begin
    addr_d   = addr_q;
    beats_d  = beats_q;
    we_d     = we_q;
    rvalid_d = (state_q == BURST) && !we_q;
    rdata_d  = rvalid_d ? mem_rdata : rdata_q;
    if (grant) begin
      addr_d  = dma_addr;
      beats_d = dma_len;
      we_d    = dma_we;
    end else if (state_q == BURST) begin
      addr_d  = addr_q + DM_ADDRESS'(4);
      beats_d = beats_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q   <= '0;
      beats_q  <= '0;
      we_q     <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      beats_q  <= beats_d;
      we_q     <= we_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign dma_rvalid = rvalid_q;
  assign dma_rdata  = rdata_q;

  // Combinational outputs are held low while reset is asserted.
  always_comb begin
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_funct3 = '0;
    core_rdata = '0;
    core_stall = 1'b0;
    dma_gnt    = 1'b0;
    dma_wready = 1'b0;
    dma_done   = 1'b0;
    if (reset_n) begin
      unique case (state_q)
        BURST: begin
          mem_rd     = ~we_q;
          mem_wr     = we_q;
          mem_addr   = addr_q;
          mem_wdata  = dma_wdata;
          mem_funct3 = FUNCT3_WORD;
          dma_wready = we_q;
          core_stall = core_busy;
        end
        default: begin
          dma_gnt  = grant;
          dma_done = (state_q == DONE);
          if (grant && core_busy) begin
            core_stall = 1'b1;
          end else begin
            mem_rd     = core_rd;
            mem_wr     = core_wr;
            mem_addr   = core_addr;
            mem_wdata  = core_wdata;
            mem_funct3 = core_funct3;
            core_rdata = mem_rdata;
          end
        end
      endcase
    end
  end

endmodule
